// File: rtl/nibble_addsub_seq.sv
// Sequential WIDTH-bit adder/subtractor built on one shared 4-bit slice, LSB nibble first.
// Define ADDSUB_OVF_EN to build signed-overflow detection; otherwise ovf is tied to 0.
module nibble_addsub_seq #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned NIB = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e state_q, state_d;

    logic [NIB-1:0][3:0] op_a_q, op_a_d;
    logic [NIB-1:0][3:0] op_b_q, op_b_d;
    logic [NIB-1:0][3:0] sum_q, sum_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic                done_q, done_d;

    logic       accept;
    logic       last;
    logic [4:0] nib_sum;

    assign accept  = (state_q == StIdle) && start;
    assign last    = (state_q == StRun) && (idx_q == LastIdx);
    // The single shared 4-bit slice; every RUN cycle feeds it the nibble selected by idx_q.
    assign nib_sum = {1'b0, op_a_q[idx_q]} + {1'b0, op_b_q[idx_q]} + {4'd0, carry_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (idx_q == LastIdx) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        if (accept) begin
            // Subtraction is A + ~B + 1: invert B once here and seed the carry with op.
            op_a_d  = a;
            op_b_d  = op ? ~b : b;
            carry_d = op;
            idx_d   = '0;
            sum_d   = '0;
        end else if (state_q == StRun) begin
            sum_d[idx_q] = nib_sum[3:0];
            carry_d      = nib_sum[4];
            idx_d        = idx_q + IdxW'(1);
            if (last) begin
                cout_d = nib_sum[4];
                done_d = 1'b1;
                idx_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

`ifdef ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // Operand MSBs live in the top nibble, so the flag is ready on the final slice cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (last) begin
            ovf_d = (op_a_q[NIB-1][3] == op_b_q[NIB-1][3]) &&
                    (nib_sum[3] != op_a_q[NIB-1][3]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_comb begin
        busy   = (state_q == StRun);
        done   = done_q;
        result = sum_q;
        cout   = cout_q;
    end

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Self-checking bench for nibble_addsub_seq (WIDTH=16): directed table, handshake and reset
// sequences, and random operations checked against a plain-arithmetic model.
module tb_nibble_addsub_seq;

    localparam int W = 16;
    localparam int NibSteps = W / 4;
`ifdef ADDSUB_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int failures = 0;

    nibble_addsub_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: unsigned arithmetic for result/cout, signed integers for overflow.
    function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0] full;
        int sx, sy, st;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (o) begin
            full = {1'b0, x} - {1'b0, y};
            c    = (x >= y);
            st   = sx - sy;
        end else begin
            full = {1'b0, x} + {1'b0, y};
            c    = full[W];
            st   = sx + sy;
        end
        r = full[W-1:0];
        v = OvfEn && ((st > 32767) || (st < -32768));
    endfunction

    // Caller is at a negedge; returns at the negedge where done is high (or the bound expired).
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic c, output logic v,
                          output int lat, output bit busy_ok);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start   = 1'b0;
        op      = 1'($urandom);
        a       = W'($urandom);
        b       = W'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        r = result;
        c = cout;
        v = ovf;
    endtask

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } vec_t;

    vec_t         vecs[6];
    logic [W-1:0] got_r, exp_r;
    logic         got_c, exp_c, got_v, exp_v;
    int           lat;
    bit           busy_ok;

    initial begin
        vecs[0] = '{op: 1'b0, a: 16'h1234, b: 16'h0FFF, r: 16'h2233, c: 1'b0, v: 1'b0};
        vecs[1] = '{op: 1'b0, a: 16'hFFFF, b: 16'h0001, r: 16'h0000, c: 1'b1, v: 1'b0};
        vecs[2] = '{op: 1'b1, a: 16'h5000, b: 16'h0001, r: 16'h4FFF, c: 1'b1, v: 1'b0};
        vecs[3] = '{op: 1'b1, a: 16'h0001, b: 16'h0002, r: 16'hFFFF, c: 1'b0, v: 1'b0};
        vecs[4] = '{op: 1'b0, a: 16'h7FFF, b: 16'h0001, r: 16'h8000, c: 1'b0, v: OvfEn};
        vecs[5] = '{op: 1'b1, a: 16'h8000, b: 16'h0001, r: 16'h7FFF, c: 1'b1, v: OvfEn};

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, got_r, got_c, got_v, lat, busy_ok);
            chk($sformatf("vec%0d_latency", i), lat, NibSteps);
            chk($sformatf("vec%0d_busy", i), busy_ok, 1);
            chk($sformatf("vec%0d_result", i), got_r, vecs[i].r);
            chk($sformatf("vec%0d_cout", i), got_c, vecs[i].c);
            chk($sformatf("vec%0d_ovf", i), got_v, vecs[i].v);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), done, 0);
            chk($sformatf("vec%0d_result_hold", i), result, vecs[i].r);
            chk($sformatf("vec%0d_idle", i), busy, 0);
        end

        // start two cycles into an operation must be ignored
        start = 1'b1;
        op    = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_done_edge", lat, 1);
        chk("ignore_result", result, 16'h3333);
        chk("ignore_cout", cout, 0);
        @(negedge clk);
        chk("ignore_no_queue", busy, 0);

        // back-to-back: second start lands in the done cycle
        run_op(1'b0, 16'h00F0, 16'h0010, got_r, got_c, got_v, lat, busy_ok);
        chk("b2b_first_result", got_r, 16'h0100);
        run_op(1'b1, 16'h0100, 16'h0001, got_r, got_c, got_v, lat, busy_ok);
        chk("b2b_second_latency", lat, NibSteps);
        chk("b2b_second_busy", busy_ok, 1);
        chk("b2b_second_result", got_r, 16'h00FF);
        chk("b2b_second_cout", got_c, 1);
        @(negedge clk);

        // asynchronous reset after two RUN edges
        start = 1'b1;
        op    = 1'b0;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(1'b0, 16'h00FF, 16'h0001, got_r, got_c, got_v, lat, busy_ok);
        chk("postrst_latency", lat, NibSteps);
        chk("postrst_result", got_r, 16'h0100);
        chk("postrst_cout", got_c, 0);

        // random operations, sometimes back-to-back
        for (int i = 0; i < 40; i++) begin
            logic         ro;
            logic [W-1:0] ra, rb;
            ro = 1'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            model(ro, ra, rb, exp_r, exp_c, exp_v);
            run_op(ro, ra, rb, got_r, got_c, got_v, lat, busy_ok);
            chk($sformatf("rnd%0d_latency", i), lat, NibSteps);
            chk($sformatf("rnd%0d_result", i), got_r, exp_r);
            chk($sformatf("rnd%0d_cout", i), got_c, exp_c);
            chk($sformatf("rnd%0d_ovf", i), got_v, exp_v);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
